// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, abort detect, zero-bit destuffing and
// LSB-first byte assembly, with registered frame-status pulses.
module hdlc_rx_deframer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_EoF,
  output logic       Rx_FrameError
);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t     state;
  logic [7:0] sr;
  logic [3:0] fill;
  logic [2:0] onesCnt;
  logic [2:0] bitCnt;
  logic [7:0] byteReg;
  logic       byteDone;
  logic       bytesSeen;

  logic flagHit, abortHit, cand, exitBit, stuffed, dataBit;

  // Patterns only count once the window holds 8 real line bits, so the
  // cleared window after reset cannot fake a leading zero.
  always_comb begin
    flagHit  = (fill == 4'd8) && (sr == 8'h7E);
    abortHit = (fill == 4'd8) && (sr == 8'h7F);
    exitBit  = sr[7];
    // The bit leaving on a flag/abort decode edge is that pattern's leading 0.
    cand     = (state == FRAME) && (fill == 4'd8) && !flagHit && !abortHit;
    stuffed  = cand && !exitBit && (onesCnt == 3'd5);
    dataBit  = cand && !stuffed;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= HUNT;
      sr             <= 8'h00;
      fill           <= 4'd0;
      onesCnt        <= 3'd0;
      bitCnt         <= 3'd0;
      byteReg        <= 8'h00;
      byteDone       <= 1'b0;
      bytesSeen      <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_NewByte     <= 1'b0;
      Rx_Data        <= 8'h00;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
    end else begin
      sr <= {sr[6:0], Rx};
      if (fill != 4'd8) fill <= fill + 4'd1;

      Rx_FlagDetect  <= flagHit;
      Rx_AbortDetect <= abortHit;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_NewByte     <= byteDone;
      if (byteDone) Rx_Data <= byteReg;
      byteDone <= 1'b0;

      if (stuffed) begin
        onesCnt <= 3'd0;
      end else if (dataBit) begin
        if (!exitBit)               onesCnt <= 3'd0;
        else if (onesCnt != 3'd5)   onesCnt <= onesCnt + 3'd1;
        byteReg <= {exitBit, byteReg[7:1]};
        bitCnt  <= bitCnt + 3'd1;
        if (bitCnt == 3'd7) begin
          byteDone  <= 1'b1;
          bytesSeen <= 1'b1;
        end
      end

      // fill restarts at 1: the bit shifted in on this edge already follows the flag.
      case (state)
        HUNT: begin
          if (flagHit) begin
            state         <= FRAME;
            Rx_ValidFrame <= 1'b1;
            fill          <= 4'd1;
            onesCnt       <= 3'd0;
            bitCnt        <= 3'd0;
            bytesSeen     <= 1'b0;
          end
        end
        FRAME: begin
          if (flagHit) begin
            if ((bitCnt != 3'd0) || bytesSeen) begin
              Rx_EoF        <= 1'b1;
              Rx_FrameError <= (bitCnt != 3'd0);
            end
            fill      <= 4'd1;
            onesCnt   <= 3'd0;
            bitCnt    <= 3'd0;
            bytesSeen <= 1'b0;
          end else if (abortHit) begin
            state         <= HUNT;
            Rx_ValidFrame <= 1'b0;
            onesCnt       <= 3'd0;
            bitCnt        <= 3'd0;
            bytesSeen     <= 1'b0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
